// File: rtl/cmp_mon_pkg.sv
// rtl/cmp_mon_pkg.sv - shared types and helpers for the comparator result monitor
package cmp_mon_pkg;

  // The state encoding doubles as the 2-bit result code of an accepted sample.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GT   = 2'd1,
    S_LT   = 2'd2,
    S_EQ   = 2'd3
  } state_t;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_LT = 3'b010;
  localparam logic [2:0] FLAG_EQ = 3'b001;

  function automatic logic is_one_hot(input logic [2:0] flags);
    return (flags == FLAG_GT) || (flags == FLAG_LT) || (flags == FLAG_EQ);
  endfunction

  function automatic state_t flags_to_result(input logic [2:0] flags);
    case (flags)
      FLAG_GT: return S_GT;
      FLAG_LT: return S_LT;
      FLAG_EQ: return S_EQ;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// rtl/cmp_result_monitor_if.sv - sample and statistics bundle of the comparator result monitor
interface cmp_result_monitor_if #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
);
  logic             in_valid;
  logic             A_greater;
  logic             A_less;
  logic             A_equal;
  logic             clear;
  logic             out_valid;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] eq_count;
  logic [RUN_W-1:0] eq_run;
  logic             match_lock;
  logic             changed;
  logic             flag_error;

  modport master (
    output in_valid, A_greater, A_less, A_equal, clear,
    input  out_valid, gt_count, lt_count, eq_count, eq_run, match_lock, changed, flag_error
  );

  modport slave (
    input  in_valid, A_greater, A_less, A_equal, clear,
    output out_valid, gt_count, lt_count, eq_count, eq_run, match_lock, changed, flag_error
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {W{1'b1}})) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - registered one-hot check, last-result FSM and statistics
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_W   = 4,
  parameter int EQ_LOCK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  cmp_result_monitor_if.slave bus
);

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] LOCK_TH = RUN_W'(EQ_LOCK);

  logic [2:0]       w_flags;
  logic             w_one_hot;
  state_t           w_result;
  logic             w_accept;
  logic             w_bad;
  logic [RUN_W-1:0] w_run_next;

  state_t           r_state;
  logic             r_out_valid;
  logic             r_changed;
  logic             r_flag_error;
  logic             r_match_lock;
  logic [RUN_W-1:0] r_eq_run;

  assign w_flags   = {bus.A_greater, bus.A_less, bus.A_equal};
  assign w_one_hot = is_one_hot(w_flags);
  assign w_result  = flags_to_result(w_flags);
  assign w_accept  = bus.in_valid && !bus.clear && w_one_hot;
  assign w_bad     = bus.in_valid && !bus.clear && !w_one_hot;

  always_comb begin
    w_run_next = r_eq_run;
    if (w_accept) begin
      if (w_result == S_EQ) begin
        if (r_eq_run != RUN_MAX) w_run_next = r_eq_run + RUN_W'(1);
      end else begin
        w_run_next = '0;
      end
    end
  end

  // Malformed samples only touch the sticky error flag; the pulses drop to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_changed    <= 1'b0;
      r_flag_error <= 1'b0;
      r_match_lock <= 1'b0;
      r_eq_run     <= '0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_changed    <= 1'b0;
      r_flag_error <= 1'b0;
      r_match_lock <= 1'b0;
      r_eq_run     <= '0;
    end else begin
      r_out_valid <= w_accept;
      r_changed   <= w_accept && (r_state != S_IDLE) && (r_state != w_result);
      if (w_bad) r_flag_error <= 1'b1;
      if (w_accept) begin
        r_eq_run     <= w_run_next;
        r_match_lock <= (w_run_next >= LOCK_TH);
        case (r_state)
          S_IDLE, S_GT, S_LT, S_EQ: r_state <= w_result;
          default:                  r_state <= S_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept && (w_result == S_GT)),
    .i_clr   (bus.clear),
    .o_count (bus.gt_count)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept && (w_result == S_LT)),
    .i_clr   (bus.clear),
    .o_count (bus.lt_count)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_accept && (w_result == S_EQ)),
    .i_clr   (bus.clear),
    .o_count (bus.eq_count)
  );

  assign bus.out_valid  = r_out_valid;
  assign bus.changed    = r_changed;
  assign bus.flag_error = r_flag_error;
  assign bus.match_lock = r_match_lock;
  assign bus.eq_run     = r_eq_run;

endmodule

// File: doc/cmp_result_monitor.md
# cmp_result_monitor

Registered stage directly downstream of `comparator_2bit`. Samples its three result flags (`A_greater`, `A_less`, `A_equal`) on a valid strobe, checks they are one-hot, and tracks the last result in a small FSM. It keeps saturating per-result event counters and a consecutive-equal run length, and asserts a lock flag once equality has held long enough. It gives the system a stable, clocked view of a purely combinational comparison.

## Interface
- `CNT_W`, 8: width of each event counter.
- `RUN_W`, 4: width of the consecutive-equal run counter.
- `EQ_LOCK`, 4: run length at which `match_lock` asserts (1 ≤ EQ_LOCK ≤ 2^RUN_W−1).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  result flags are meaningful this cycle.
- `A_greater`  in  1  comparator flag, A > B.
- `A_less`  in  1  comparator flag, A < B.
- `A_equal`  in  1  comparator flag, A == B.
- `clear`  in  1  synchronous clear of all statistics and state.
- `out_valid`  out  1  registered copy of an accepted sample.
- `gt_count`  out  CNT_W  number of accepted GT samples, saturating.
- `lt_count`  out  CNT_W  number of accepted LT samples, saturating.
- `eq_count`  out  CNT_W  number of accepted EQ samples, saturating.
- `eq_run`  out  RUN_W  current count of consecutive EQ samples, saturating.
- `match_lock`  out  1  `eq_run` ≥ EQ_LOCK.
- `changed`  out  1  one-cycle pulse: the result differs from the previous accepted result.
- `flag_error`  out  1  sticky: a non-one-hot flag set was seen while `in_valid` was high.

## Operation
- **Reset.** While `rst_n` is low, all outputs are 0 and the FSM is in S_IDLE.
- **FSM states.** The FSM holds the last accepted result:
  - S_IDLE: no sample accepted since reset or clear.
  - S_GT, S_LT, S_EQ: the last accepted sample was GT, LT or EQ.
- **Accepted sample.** `in_valid`=1, `clear`=0, and exactly one of the three flags is set.
  - The FSM moves to the matching state.
  - The matching counter increments by 1 and holds at 2^CNT_W−1.
  - `out_valid` pulses.
- **`changed`.** Pulses when the previous state was S_GT, S_LT or S_EQ and differs from the new state. It never pulses on a transition out of S_IDLE.
- **`eq_run`.**
  - EQ sample: `eq_run` increments, saturating at 2^RUN_W−1.
  - GT or LT sample: `eq_run` returns to 0.
  - `match_lock` is registered and equals (next `eq_run` ≥ EQ_LOCK). It drops on the first GT or LT sample.
- **Invalid sample.** `in_valid`=1 and the flags are not one-hot (zero set, or more than one set).
  - `flag_error` sets and stays set.
  - Nothing else changes: no counter update, no state change, `out_valid`=0, `changed`=0.
- **`in_valid`=0.** All state holds. Flags are ignored, including non-one-hot values.
- **`clear`=1.**
  - Next edge: counters, `eq_run`, `match_lock` and `flag_error` go to 0, and the FSM goes to S_IDLE.
  - `clear` takes priority over a simultaneous `in_valid`; that sample is discarded.
- **Counter width.** Counter arithmetic is CNT_W bits wide, with saturation compared against all-ones. Counters never wrap.

## Timing
- Latency is 1 cycle: a sample presented at edge N is reflected on all outputs after edge N.
- Every output is driven directly from a flop; there are no combinational input-to-output paths.
- `out_valid` and `changed` are high for exactly one cycle per accepted sample. With back-to-back valid samples they can stay high on consecutive cycles.
- Reset mid-stream: asserting `rst_n` low zeros the outputs immediately (asynchronous). Operation resumes on the first edge after release, starting from S_IDLE.
- Counters reach saturation after exactly 2^CNT_W−1 accepted samples of one kind.

## Structure
- Package `cmp_mon_pkg`:
  - state enum (S_IDLE, S_GT, S_LT, S_EQ);
  - 2-bit result encoding;
  - one-hot check function.
- Sub-module `sat_counter`, parameterised by width, with inc and clr inputs:
  - three instances for `gt_count`, `lt_count` and `eq_count`;
  - `eq_run` uses its own counter because it also has a reset-on-mismatch path.

## Test plan
- **Basic sequence.** Reset, then valid samples EQ, LT, GT, EQ, GT, LT.
  - Counts gt=2, lt=2, eq=2.
  - `changed` pulses on samples 2–6, not on sample 1.
- **Equality lock (EQ_LOCK=4).**
  - 5 consecutive EQ samples: `eq_run` reads 1, 2, 3, 4, 5; `match_lock` rises after the 4th.
  - Then one GT: `eq_run`=0 and `match_lock`=0 one cycle later.
- **Error path.** Flags 3'b110 with `in_valid`=1, then 3'b000 with `in_valid`=1.
  - `flag_error`=1 and stays 1.
  - Counts and state are unchanged; `out_valid` stays 0.
- **Saturation (CNT_W=8).** 300 GT samples.
  - `gt_count`=255 with no wrap.
  - `eq_run` stays at 0 throughout.
- **Clear collision.** `clear` and a valid EQ sample in the same cycle.
  - Everything reads 0 and `out_valid`=0.
  - The next EQ sample gives `eq_count`=1 and `changed`=0.
- **Async reset mid-run.** Pull `rst_n` low between clock edges after 3 EQ samples.
  - All outputs go to 0 before the next edge.
  - After release, the first LT sample gives `changed`=0 and `lt_count`=1.
